// File: rtl/tff_count_sched_pkg.sv
// Shared state encodings and direction constants for the T-flip-flop count sequencer.
package tff_count_sched_pkg;

   typedef enum logic [2:0] {
      StIdle = 3'd0,
      StLoad = 3'd1,
      StRun  = 3'd2,
      StHold = 3'd3,
      StDone = 3'd4
   } state_e;

   localparam logic DirUp = 1'b0;
   localparam logic DirDn = 1'b1;

endpackage

// File: rtl/tff_count_sched_bank.sv
// Bank of toggle flip-flops: each bit inverts when its T input is high.
module tff_count_sched_bank #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             Clk,
   input  logic             Rstn,
   input  logic [WIDTH-1:0] T,
   output logic [WIDTH-1:0] Q
);

   // Toggle register; the only path that changes Q.
   always_ff @(posedge Clk or negedge Rstn) begin
      if (!Rstn) begin
         Q <= '0;
      end else begin
         Q <= Q ^ T;
      end
   end

endmodule

// File: rtl/tff_count_sched.sv
// One-shot up/down counter sequencer driving a toggle flip-flop bank.
module tff_count_sched
   import tff_count_sched_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic             Clk,
   input  logic             Rstn,
   input  logic             Start,
   input  logic             Stop,
   input  logic             Dir,
   input  logic [WIDTH-1:0] Limit,
   output logic [WIDTH-1:0] Count,
   output logic [WIDTH-1:0] T_vec,
   output logic             Busy,
   output logic             Done
);

   state_e           state_q, state_d;
   logic             dir_r;
   logic [WIDTH-1:0] limit_r;
   logic [WIDTH-1:0] init_val;
   logic [WIDTH-1:0] step_vec;
   logic             term;

   tff_count_sched_bank #(
      .WIDTH (WIDTH)
   ) u_bank (
      .Clk  (Clk),
      .Rstn (Rstn),
      .T    (T_vec),
      .Q    (Count)
   );

   // State register.
   always_ff @(posedge Clk or negedge Rstn) begin
      if (!Rstn) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Capture direction and limit only when a count is accepted from idle.
   always_ff @(posedge Clk or negedge Rstn) begin
      if (!Rstn) begin
         dir_r   <= DirUp;
         limit_r <= '0;
      end else if (state_q == StIdle && Start) begin
         dir_r   <= Dir;
         limit_r <= Limit;
      end
   end

   // Load target and terminal detection.
   always_comb begin
      init_val = (dir_r == DirDn) ? limit_r : '0;
      term     = (dir_r == DirDn) ? (Count == '0) : (Count == limit_r);
   end

   // Ripple toggle vector: a bit toggles when all lower bits are 1 (up) or 0 (down).
   always_comb begin
      logic carry;
      step_vec = '0;
      carry    = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
         step_vec[i] = carry;
         carry       = carry & ((dir_r == DirDn) ? ~Count[i] : Count[i]);
      end
   end

   // Next-state and toggle vector selection.
   always_comb begin
      state_d = state_q;
      T_vec   = '0;
      unique case (state_q)
         StIdle: begin
            if (Start) state_d = StLoad;
         end
         StLoad: begin
            // Toggle exactly the bits that differ from the start value.
            T_vec   = Count ^ init_val;
            state_d = StRun;
         end
         StRun: begin
            if (Stop) begin
               state_d = StHold;
            end else if (term) begin
               state_d = StDone;
            end else begin
               T_vec = step_vec;
            end
         end
         StHold: begin
            if (Stop) begin
               state_d = StIdle;
            end else if (Start) begin
               state_d = StRun;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Status flags decoded from the state register.
   always_comb begin
      Busy = (state_q == StLoad) || (state_q == StRun) || (state_q == StHold);
      Done = (state_q == StDone);
   end

endmodule

// File: tb/tb_tff_count_sched.sv
// Directed self-checking bench for tff_count_sched (WIDTH=4).
module tb_tff_count_sched;

   logic       Clk;
   logic       Rstn;
   logic       Start;
   logic       Stop;
   logic       Dir;
   logic [3:0] Limit;
   logic [3:0] Count;
   logic [3:0] T_vec;
   logic       Busy;
   logic       Done;

   int checks = 0;
   int errors = 0;

   tff_count_sched #(
      .WIDTH (4)
   ) dut (
      .Clk   (Clk),
      .Rstn  (Rstn),
      .Start (Start),
      .Stop  (Stop),
      .Dir   (Dir),
      .Limit (Limit),
      .Count (Count),
      .T_vec (T_vec),
      .Busy  (Busy),
      .Done  (Done)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_st(input string tag, input logic [3:0] cnt, input logic [3:0] tv,
                            input logic busy, input logic done);
      chk({tag, ".count"}, {28'd0, Count}, {28'd0, cnt});
      chk({tag, ".tvec"},  {28'd0, T_vec}, {28'd0, tv});
      chk({tag, ".busy"},  {31'd0, Busy},  {31'd0, busy});
      chk({tag, ".done"},  {31'd0, Done},  {31'd0, done});
   endtask

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   initial begin
      // 1. Asynchronous reset with random inputs, no clock edge yet.
      Rstn  = 1'b1;
      Start = 1'($urandom);
      Stop  = 1'($urandom);
      Dir   = 1'($urandom);
      Limit = 4'($urandom);
      #1 Rstn = 1'b0;
      #1 expect_st("reset", 4'd0, 4'd0, 1'b0, 1'b0);
      Start = 1'b0; Stop = 1'b0; Dir = 1'b0; Limit = 4'd0;
      step();
      step();
      Rstn = 1'b1;
      step();
      expect_st("idle_after_reset", 4'd0, 4'd0, 1'b0, 1'b0);

      // 2. Up count to 3.
      Start = 1'b1; Dir = 1'b0; Limit = 4'd3;
      step();
      expect_st("up3.load", 4'd0, 4'd0, 1'b1, 1'b0);
      Start = 1'b0; Dir = 1'b1; Limit = 4'd15;  // ignored while busy
      step(); expect_st("up3.c0", 4'd0, 4'b0001, 1'b1, 1'b0);
      step(); expect_st("up3.c1", 4'd1, 4'b0011, 1'b1, 1'b0);
      step(); expect_st("up3.c2", 4'd2, 4'b0001, 1'b1, 1'b0);
      step(); expect_st("up3.c3", 4'd3, 4'b0000, 1'b1, 1'b0);
      step(); expect_st("up3.done", 4'd3, 4'b0000, 1'b0, 1'b1);
      step(); expect_st("up3.idle", 4'd3, 4'b0000, 1'b0, 1'b0);

      // 3. Down count from preloaded 3 with Limit=5.
      Start = 1'b1; Dir = 1'b1; Limit = 4'd5;
      step(); expect_st("dn5.load", 4'd3, 4'b0110, 1'b1, 1'b0);
      Start = 1'b0;
      step(); expect_st("dn5.c5", 4'd5, 4'b0001, 1'b1, 1'b0);
      step(); expect_st("dn5.c4", 4'd4, 4'b0111, 1'b1, 1'b0);
      step(); expect_st("dn5.c3", 4'd3, 4'b0001, 1'b1, 1'b0);
      step(); expect_st("dn5.c2", 4'd2, 4'b0011, 1'b1, 1'b0);
      step(); expect_st("dn5.c1", 4'd1, 4'b0001, 1'b1, 1'b0);
      step(); expect_st("dn5.c0", 4'd0, 4'b0000, 1'b1, 1'b0);
      step(); expect_st("dn5.done", 4'd0, 4'b0000, 1'b0, 1'b1);
      step(); expect_st("dn5.idle", 4'd0, 4'b0000, 1'b0, 1'b0);

      // 4. Pause at 2, hold 4 cycles, resume to 9.
      Start = 1'b1; Dir = 1'b0; Limit = 4'd9;
      step(); expect_st("p9.load", 4'd0, 4'b0000, 1'b1, 1'b0);
      Start = 1'b0;
      step(); expect_st("p9.c0", 4'd0, 4'b0001, 1'b1, 1'b0);
      step(); expect_st("p9.c1", 4'd1, 4'b0011, 1'b1, 1'b0);
      step(); expect_st("p9.c2", 4'd2, 4'b0001, 1'b1, 1'b0);
      Stop = 1'b1;
      #1 chk("p9.stop_tvec", {28'd0, T_vec}, 32'd0);
      step(); expect_st("p9.hold0", 4'd2, 4'b0000, 1'b1, 1'b0);
      Stop = 1'b0;
      step(); expect_st("p9.hold1", 4'd2, 4'b0000, 1'b1, 1'b0);
      step(); expect_st("p9.hold2", 4'd2, 4'b0000, 1'b1, 1'b0);
      step(); expect_st("p9.hold3", 4'd2, 4'b0000, 1'b1, 1'b0);
      Start = 1'b1;
      step(); expect_st("p9.resume", 4'd2, 4'b0001, 1'b1, 1'b0);
      Start = 1'b0;
      for (int i = 3; i <= 9; i++) begin
         step();
         chk($sformatf("p9.run%0d", i), {28'd0, Count}, i);
         chk($sformatf("p9.busy%0d", i), {31'd0, Busy}, 32'd1);
      end
      chk("p9.term_tvec", {28'd0, T_vec}, 32'd0);
      step(); expect_st("p9.done", 4'd9, 4'b0000, 1'b0, 1'b1);
      step(); expect_st("p9.idle", 4'd9, 4'b0000, 1'b0, 1'b0);

      // 4b. Abort from HOLD with Start and Stop together.
      Start = 1'b1; Dir = 1'b0; Limit = 4'd9;
      step(); expect_st("ab.load", 4'd9, 4'b1001, 1'b1, 1'b0);
      Start = 1'b0;
      step(); expect_st("ab.c0", 4'd0, 4'b0001, 1'b1, 1'b0);
      step(); expect_st("ab.c1", 4'd1, 4'b0011, 1'b1, 1'b0);
      Stop = 1'b1;
      step(); expect_st("ab.hold", 4'd1, 4'b0000, 1'b1, 1'b0);
      Start = 1'b1;
      step(); expect_st("ab.idle", 4'd1, 4'b0000, 1'b0, 1'b0);
      Start = 1'b0; Stop = 1'b0;
      step(); expect_st("ab.nodone", 4'd1, 4'b0000, 1'b0, 1'b0);

      // 5a. Limit=0 up: Done three edges after Start.
      Start = 1'b1; Dir = 1'b0; Limit = 4'd0;
      step(); expect_st("l0.load", 4'd1, 4'b0001, 1'b1, 1'b0);
      Start = 1'b0;
      step(); expect_st("l0.run", 4'd0, 4'b0000, 1'b1, 1'b0);
      step(); expect_st("l0.done", 4'd0, 4'b0000, 1'b0, 1'b1);
      step(); expect_st("l0.idle", 4'd0, 4'b0000, 1'b0, 1'b0);

      // 5b/5c. Limit=15 up with Start held high throughout.
      Start = 1'b1; Dir = 1'b0; Limit = 4'd15;
      step(); expect_st("l15.load", 4'd0, 4'b0000, 1'b1, 1'b0);
      step(); expect_st("l15.c0", 4'd0, 4'b0001, 1'b1, 1'b0);
      for (int i = 1; i <= 15; i++) begin
         step();
         chk($sformatf("l15.run%0d", i), {28'd0, Count}, i);
      end
      chk("l15.term_tvec", {28'd0, T_vec}, 32'd0);
      chk("l15.term_busy", {31'd0, Busy}, 32'd1);
      step(); expect_st("l15.done", 4'd15, 4'b0000, 1'b0, 1'b1);
      step(); expect_st("l15.idle", 4'd15, 4'b0000, 1'b0, 1'b0);
      step(); expect_st("l15.retrig", 4'd15, 4'b1111, 1'b1, 1'b0);
      Start = 1'b0;

      // 6. Reset mid-run at Count=6.
      step(); expect_st("rs.c0", 4'd0, 4'b0001, 1'b1, 1'b0);
      for (int i = 1; i <= 6; i++) step();
      expect_st("rs.c6", 4'd6, 4'b0001, 1'b1, 1'b0);
      Rstn = 1'b0;
      #1 expect_st("rs.async", 4'd0, 4'b0000, 1'b0, 1'b0);
      step(); expect_st("rs.held", 4'd0, 4'b0000, 1'b0, 1'b0);
      Rstn = 1'b1;
      step(); expect_st("rs.idle", 4'd0, 4'b0000, 1'b0, 1'b0);
      Start = 1'b1; Dir = 1'b0; Limit = 4'd2;
      step(); expect_st("rs2.load", 4'd0, 4'b0000, 1'b1, 1'b0);
      Start = 1'b0;
      step(); expect_st("rs2.c0", 4'd0, 4'b0001, 1'b1, 1'b0);
      step(); expect_st("rs2.c1", 4'd1, 4'b0011, 1'b1, 1'b0);
      step(); expect_st("rs2.c2", 4'd2, 4'b0000, 1'b1, 1'b0);
      step(); expect_st("rs2.done", 4'd2, 4'b0000, 1'b0, 1'b1);
      step(); expect_st("rs2.idle", 4'd2, 4'b0000, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
